// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit bridging the EX/MEM stage to a handshaked data SRAM
// Four-state FSM: accept in IDLE, hold the request in REQ/DRAIN, one-cycle result strobe in DONE.
module mem_lsu (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        ls_valid,
  input  logic [3:0]  ls_op,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic        flush,
  output logic        stall_req,
  output logic        data_req,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_ack,
  input  logic [31:0] data_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [3:0]  ld_dre,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] badvaddr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] ld_data_q;
  logic [3:0]  ld_dre_q;

  // Access size: 0 = not a memory op, 1 = byte, 2 = half, 3 = word.
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0010, 4'b1001: op_size = 2'd1;
      4'b0011, 4'b0100, 4'b1010: op_size = 2'd2;
      4'b0101, 4'b1011:          op_size = 2'd3;
      default:                   op_size = 2'd0;
    endcase
  endfunction

  logic [1:0]  in_size;
  logic        misaligned;
  logic        new_op;
  logic        accept;
  logic        addr_exc;
  logic        busy;
  logic [1:0]  q_size;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [31:0] shifted;
  logic [31:0] ld_fmt;

  assign in_size    = op_size(ls_op);
  assign misaligned = ((in_size == 2'd2) && ls_addr[0]) ||
                      ((in_size == 2'd3) && (ls_addr[1:0] != 2'b00));
  assign new_op     = (state_q == IDLE) && ls_valid && (in_size != 2'd0) && !flush && !cpu_rst;
  assign accept     = new_op && !misaligned;
  assign addr_exc   = new_op && misaligned;

  assign exc_adel = addr_exc && !ls_op[3];
  assign exc_ades = addr_exc && ls_op[3];
  assign badvaddr = addr_exc ? ls_addr : 32'd0;

  assign busy   = (state_q == REQ) || (state_q == DRAIN);
  assign q_size = op_size(op_q);

  always_comb begin
    be_q = 4'b0000;
    wd_q = wdata_q;
    case (q_size)
      2'd1: begin
        be_q = 4'b0001 << addr_q[1:0];
        wd_q = {4{wdata_q[7:0]}};
      end
      2'd2: begin
        be_q = 4'b0011 << addr_q[1:0];
        wd_q = {2{wdata_q[15:0]}};
      end
      2'd3: be_q = 4'b1111;
      default: be_q = 4'b0000;
    endcase
  end

  // Alignment is guaranteed at accept, so a plain lane shift lands the data at bit 0.
  assign shifted = data_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_fmt = shifted;
    case (op_q)
      4'b0001: ld_fmt = {{24{shifted[7]}}, shifted[7:0]};
      4'b0010: ld_fmt = {24'd0, shifted[7:0]};
      4'b0011: ld_fmt = {{16{shifted[15]}}, shifted[15:0]};
      4'b0100: ld_fmt = {16'd0, shifted[15:0]};
      default: ld_fmt = shifted;
    endcase
  end

  assign data_req   = busy;
  assign data_we    = busy && op_q[3];
  assign data_be    = busy ? be_q : 4'b0000;
  assign data_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign data_wdata = busy ? wd_q : 32'd0;

  assign stall_req = !cpu_rst && (accept || (state_q == REQ) || ((state_q == DRAIN) && ls_valid));
  assign ld_valid  = (state_q == DONE) && !op_q[3] && !flush;
  assign ld_data   = ld_data_q;
  assign ld_dre    = ld_dre_q;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q   <= IDLE;
      op_q      <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      ld_data_q <= 32'd0;
      ld_dre_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= ls_op;
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (data_ack) begin
            if (flush) begin
              state_q <= IDLE;
            end else begin
              state_q <= DONE;
              if (!op_q[3]) begin
                ld_data_q <= ld_fmt;
                ld_dre_q  <= be_q;
              end
            end
          end else if (flush) begin
            state_q <= DRAIN;
          end
        end
        DONE:  state_q <= IDLE;
        DRAIN: if (data_ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid;
  logic [3:0]  ls_op;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        flush;
  logic        stall_req;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [3:0]  ld_dre;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] badvaddr;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt;
  int ldv_cnt;

  mem_lsu dut (
    .cpu_clk_50M(clk),
    .cpu_rst(rst),
    .ls_valid(ls_valid),
    .ls_op(ls_op),
    .ls_addr(ls_addr),
    .ls_wdata(ls_wdata),
    .flush(flush),
    .stall_req(stall_req),
    .data_req(data_req),
    .data_we(data_we),
    .data_be(data_be),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_ack(data_ack),
    .data_rdata(data_rdata),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_dre(ld_dre),
    .exc_adel(exc_adel),
    .exc_ades(exc_ades),
    .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
    ls_valid = v;
    ls_op    = op;
    ls_addr  = a;
    ls_wdata = wd;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    flush = 1'b0;
    data_ack = 1'b0;
    data_rdata = 32'd0;

    // Reset: every output low even with a misaligned load presented
    @(negedge clk);
    drive(1'b1, 4'b0101, 32'h0000_0101, 32'd0);
    #1;
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_adel", {31'd0, exc_adel}, 32'd0);
    chk("rst_badv", badvaddr, 32'd0);
    chk("rst_lddata", ld_data, 32'd0);
    chk("rst_ldv", {31'd0, ld_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);

    // LB 0x1003, ack in first REQ cycle
    @(negedge clk);
    drive(1'b1, 4'b0001, 32'h0000_1003, 32'd0);
    #1;
    chk("lb_acc_stall", {31'd0, stall_req}, 32'd1);
    chk("lb_acc_req", {31'd0, data_req}, 32'd0);
    @(negedge clk);
    data_ack = 1'b1; data_rdata = 32'h80FF_0000;
    #1;
    chk("lb_req", {31'd0, data_req}, 32'd1);
    chk("lb_be", {28'd0, data_be}, 32'h8);
    chk("lb_we", {31'd0, data_we}, 32'd0);
    chk("lb_addr", data_addr, 32'h0000_1000);
    chk("lb_req_stall", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    data_ack = 1'b0;
    #1;
    chk("lb_ldv", {31'd0, ld_valid}, 32'd1);
    chk("lb_data", ld_data, 32'hFFFF_FF80);
    chk("lb_dre", {28'd0, ld_dre}, 32'h8);
    chk("lb_done_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    ls_valid = 1'b0;
    #1;
    chk("lb_idle_req", {31'd0, data_req}, 32'd0);
    chk("lb_idle_ldv", {31'd0, ld_valid}, 32'd0);

    // SH 0x2002 with three ack wait cycles
    stall_cnt = 0; ldv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b1, 4'b1010, 32'h0000_2002, 32'h1234_ABCD);
      if (c == 5) ls_valid = 1'b0;
      data_ack = (c == 4);
      #1;
      stall_cnt += int'(stall_req);
      ldv_cnt += int'(ld_valid);
      if (c == 3 || c == 4) begin
        chk("sh_we", {31'd0, data_we}, 32'd1);
        chk("sh_be", {28'd0, data_be}, 32'hC);
        chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
        chk("sh_addr", data_addr, 32'h0000_2000);
      end
    end
    data_ack = 1'b0;
    chk("sh_stall_cycles", stall_cnt, 32'd5);
    chk("sh_no_ldv", ldv_cnt, 32'd0);

    // Misaligned LW / SW, invalid op, flush masking an exception
    @(negedge clk);
    drive(1'b1, 4'b0101, 32'h0000_3001, 32'd0);
    #1;
    chk("lw_mis_adel", {31'd0, exc_adel}, 32'd1);
    chk("lw_mis_ades", {31'd0, exc_ades}, 32'd0);
    chk("lw_mis_badv", badvaddr, 32'h0000_3001);
    chk("lw_mis_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    drive(1'b1, 4'b1011, 32'h0000_3002, 32'd0);
    #1;
    chk("lw_mis_noreq", {31'd0, data_req}, 32'd0);
    chk("sw_mis_ades", {31'd0, exc_ades}, 32'd1);
    chk("sw_mis_adel", {31'd0, exc_adel}, 32'd0);
    chk("sw_mis_badv", badvaddr, 32'h0000_3002);
    @(negedge clk);
    drive(1'b1, 4'b0111, 32'h0000_3000, 32'd0);
    #1;
    chk("sw_mis_noreq", {31'd0, data_req}, 32'd0);
    chk("inv_stall", {31'd0, stall_req}, 32'd0);
    chk("inv_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
    @(negedge clk);
    drive(1'b1, 4'b0101, 32'h0000_3001, 32'd0);
    flush = 1'b1;
    #1;
    chk("inv_noreq", {31'd0, data_req}, 32'd0);
    chk("flush_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
    chk("flush_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    ls_valid = 1'b0;
    #1;
    chk("flush_noreq", {31'd0, data_req}, 32'd0);

    // LHU 0x4000, flush in first REQ cycle, ack two cycles later
    @(negedge clk);
    drive(1'b1, 4'b0100, 32'h0000_4000, 32'd0);
    #1;
    chk("lhu_acc", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("lhu_req", {31'd0, data_req}, 32'd1);
    @(negedge clk);
    flush = 1'b0; ls_valid = 1'b0;
    #1;
    chk("drain_req", {31'd0, data_req}, 32'd1);
    chk("drain_be", {28'd0, data_be}, 32'h3);
    chk("drain_stall0", {31'd0, stall_req}, 32'd0);
    drive(1'b1, 4'b0101, 32'h0000_4100, 32'd0);
    #1;
    chk("drain_stall1", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    data_ack = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("drain_req_ack", {31'd0, data_req}, 32'd1);
    chk("drain_addr", data_addr, 32'h0000_4000);
    chk("drain_ldv", {31'd0, ld_valid}, 32'd0);
    @(negedge clk);
    data_ack = 1'b0; ls_valid = 1'b0;
    #1;
    chk("drain_exit_req", {31'd0, data_req}, 32'd0);
    chk("drain_exit_ldv", {31'd0, ld_valid}, 32'd0);
    chk("drain_exit_stall", {31'd0, stall_req}, 32'd0);

    // Reset mid-REQ, then LBU 0x5002
    @(negedge clk);
    drive(1'b1, 4'b0101, 32'h0000_5000, 32'd0);
    @(negedge clk);
    #1;
    chk("rreq_req", {31'd0, data_req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rreq_req_drop", {31'd0, data_req}, 32'd0);
    chk("rreq_stall_drop", {31'd0, stall_req}, 32'd0);
    chk("rreq_ldv", {31'd0, ld_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4'b0010, 32'h0000_5002, 32'd0);
    #1;
    chk("lbu_acc", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    data_ack = 1'b1; data_rdata = 32'h00AB_0000;
    #1;
    chk("lbu_be", {28'd0, data_be}, 32'h4);
    @(negedge clk);
    data_ack = 1'b0; ls_valid = 1'b0;
    #1;
    chk("lbu_ldv", {31'd0, ld_valid}, 32'd1);
    chk("lbu_data", ld_data, 32'h0000_00AB);

    // Back-to-back LW: accepts at cycles 0 and 3, strobes at 2 and 5
    stall_cnt = 0; ldv_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b1, 4'b0101, 32'h0000_6000, 32'd0);
      if (c == 3) drive(1'b1, 4'b0101, 32'h0000_6004, 32'd0);
      if (c == 6) ls_valid = 1'b0;
      data_ack = (c == 1) || (c == 4);
      data_rdata = (c == 1) ? 32'h1111_1111 : 32'h2222_2222;
      #1;
      stall_cnt += int'(stall_req);
      ldv_cnt += int'(ld_valid);
      if (c == 2) begin
        chk("b2b_ldv1", {31'd0, ld_valid}, 32'd1);
        chk("b2b_data1", ld_data, 32'h1111_1111);
        chk("b2b_done_stall", {31'd0, stall_req}, 32'd0);
      end
      if (c == 3) chk("b2b_acc2", {31'd0, stall_req}, 32'd1);
      if (c == 4) chk("b2b_addr2", data_addr, 32'h0000_6004);
      if (c == 5) begin
        chk("b2b_ldv2", {31'd0, ld_valid}, 32'd1);
        chk("b2b_data2", ld_data, 32'h2222_2222);
      end
    end
    data_ack = 1'b0;
    chk("b2b_stall_cycles", stall_cnt, 32'd4);
    chk("b2b_ldv_cycles", ldv_cnt, 32'd2);

    // SB 0x8001 with flush on the ack cycle: straight back to IDLE
    @(negedge clk);
    drive(1'b1, 4'b1001, 32'h0000_8001, 32'h0000_00A5);
    @(negedge clk);
    data_ack = 1'b1; flush = 1'b1;
    #1;
    chk("sb_be", {28'd0, data_be}, 32'h2);
    chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
    chk("sb_we", {31'd0, data_we}, 32'd1);
    @(negedge clk);
    data_ack = 1'b0; flush = 1'b0; ls_valid = 1'b0;
    #1;
    chk("sb_flush_req", {31'd0, data_req}, 32'd0);
    chk("sb_flush_ldv", {31'd0, ld_valid}, 32'd0);

    // LH 0x7002 with flush in DONE: strobe suppressed
    @(negedge clk);
    drive(1'b1, 4'b0011, 32'h0000_7002, 32'd0);
    @(negedge clk);
    data_ack = 1'b1; data_rdata = 32'h8001_0000;
    @(negedge clk);
    data_ack = 1'b0; flush = 1'b1;
    #1;
    chk("lh_flush_ldv", {31'd0, ld_valid}, 32'd0);
    chk("lh_flush_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    flush = 1'b0; ls_valid = 1'b0;
    #1;
    chk("lh_idle_req", {31'd0, data_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have these ports, one clock domain, reset asynchronous and active-high:
- cpu_clk_50M  in  1  clock, all state on rising edge
- cpu_rst  in  1  asynchronous active-high reset
- ls_valid  in  1  EX/MEM holds a memory op; held stable while stall_req=1
- ls_op  in  4  0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 1001 SB, 1010 SH, 1011 SW; other codes are no-op
- ls_addr  in  32  effective address
- ls_wdata  in  32  store source (rt)
- flush  in  1  exception/ERET pipeline flush
- stall_req  out  1  hold EX/MEM and upstream
- data_req  out  1  data SRAM request
- data_we  out  1  1 = store
- data_be  out  4  byte lane enables
- data_addr  out  32  word address {addr[31:2],2'b00}
- data_wdata  out  32  lane-replicated store data
- data_ack  in  1  SRAM accepts/completes the request this cycle
- data_rdata  in  32  read word, valid with data_ack
- ld_valid  out  1  one-cycle load-result strobe
- ld_data  out  32  aligned, sign/zero-extended load result
- ld_dre  out  4  lanes read, for the MEM/WB register
- exc_adel  out  1  load address error
- exc_ades  out  1  store address error
- badvaddr  out  32  faulting address

Function
REQ-002 The FSM SHALL have four states: IDLE, REQ, DONE, DRAIN.
REQ-003 In IDLE, with ls_valid=1, a valid op, an aligned address and flush=0, the block SHALL latch op/addr/wdata, assert stall_req in the same cycle, and enter REQ.
REQ-004 Alignment SHALL be: halfword requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
REQ-005 For a misaligned op in IDLE, the block SHALL drive exc_adel (loads) or exc_ades (stores) combinationally with badvaddr=ls_addr, keep stall_req=0, issue no request, and stay in IDLE.
REQ-006 In REQ, data_req SHALL be 1 and data_we/data_be/data_addr/data_wdata SHALL be held constant from the latched op until data_ack=1 is sampled.
REQ-007 stall_req SHALL be 1 throughout REQ.
REQ-008 On data_ack in REQ, the block SHALL go to DONE, registering the formatted load data.
REQ-009 data_be SHALL be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-010 data_wdata SHALL be: byte {4{b[7:0]}}; half {2{h[15:0]}}; word unchanged.
REQ-011 Lanes SHALL be little-endian: lane 0 = bits 7:0.
REQ-012 For loads, ld_data SHALL be the selected lane(s) shifted to bit 0, sign-extended for LB/LH and zero-extended for LBU/LHU. ld_dre SHALL equal data_be.
REQ-013 In DONE, for exactly one cycle, stall_req SHALL be 0 and ld_valid SHALL be 1 (loads only); the next state SHALL be IDLE.
REQ-014 In DONE, ls_valid SHALL be ignored (it is the op just completed).
REQ-015 Minimum latency SHALL be: accept cycle 0, data_req cycle 1, ack cycle 1, ld_valid cycle 2. Each extra ack wait cycle SHALL add one cycle.
REQ-016 flush in IDLE or DONE SHALL force IDLE and suppress ld_valid and the exception outputs that cycle.
REQ-017 flush in REQ without ack SHALL enter DRAIN. flush in REQ with ack SHALL go directly to IDLE with no ld_valid.
REQ-018 In DRAIN, data_req SHALL stay asserted with the same fields until data_ack. The returned data SHALL be discarded, ld_valid SHALL be 0, and the next state SHALL be IDLE.
REQ-019 In DRAIN, stall_req SHALL equal ls_valid, and new ops SHALL NOT be accepted.
REQ-020 Invalid ls_op codes SHALL be treated as no memory op: no stall, no request, no exception.

Reset
REQ-021 Asserting cpu_rst at any time SHALL force IDLE immediately.
REQ-022 During reset, every output SHALL be 0 and latched op/addr/wdata SHALL be 0.
REQ-023 An outstanding SRAM request SHALL be abandoned on reset. The SRAM is reset by the same signal.
REQ-024 The first accept SHALL occur on the first rising edge after cpu_rst deasserts with ls_valid=1.

Verification
REQ-025 LB, addr 0x1003, rdata 0x80FF_0000, ack in REQ cycle -> data_be=1000, ld_valid in cycle 2, ld_data=0xFFFF_FF80, ld_dre=1000.
REQ-026 SH, addr 0x2002, wdata 0x1234_ABCD, ack after 3 wait cycles -> data_we=1, data_be=1100, data_wdata=0xABCD_ABCD; stall_req high for 5 cycles; ld_valid stays 0.
REQ-027 LW, addr 0x3001 -> exc_adel=1, badvaddr=0x3001, stall_req=0, data_req never asserted. SW, addr 0x3002 -> exc_ades=1.
REQ-028 LHU, addr 0x4000; flush in first REQ cycle, ack 2 cycles later -> DRAIN holds data_req until ack, ld_valid never asserts, FSM returns to IDLE.
REQ-029 cpu_rst pulsed mid-REQ -> data_req, stall_req and ld_valid drop to 0 asynchronously. The next LBU, addr 0x5002, rdata 0x00AB_0000 -> ld_data=0x0000_00AB.
REQ-030 Back-to-back LW, LW with ack on the first request cycle -> accepts at cycles 0 and 3, ld_valid at cycles 2 and 5, no duplicate accept in DONE.
